wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the in-order single-issue RV32 pipeline, directly downstream of the memory stage; consumes its rv32_mem2wb_packet_t every cycle.
- Owns the MEM/WB pipeline register, the 32x32 architectural register file (two combinational read ports for decode), the EX forwarding source, and retirement counters.

Parameters:
- XLEN, 32, data/PC width
- NREGS, 32, architectural registers; x0 hardwired to zero
- CNT_W, 64, instret counter width; load/store counters fixed at 32 bits

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold MEM/WB register and suppress commit
- flush  in  1  squash the incoming packet
- wb_in_packet  in  rv32_mem2wb_packet_t  packet from the memory stage; fields used: valid_opcode, wb_pc, wb_addr, wb_data, wb_enable, is_load, is_store, dont_forward
- rs1_addr, rs2_addr  in  5  decode read addresses
- rs1_data, rs2_data  out  XLEN  read data
- fwd_valid  out  1  forwarding source valid
- fwd_addr  out  5  forwarded destination register
- fwd_data  out  XLEN  forwarded data
- retire_valid  out  1  one instruction commits at the next edge
- retire_pc  out  XLEN  PC of the committing instruction
- instret  out  CNT_W  retired-instruction count
- load_count, store_count  out  32  retired load and store counts

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included): wb_q.valid=0 and all wb_q fields 0; all registers 0; instret, load_count and store_count 0. Resulting outputs: rs*_data=0, fwd_valid=0, fwd_addr=0, fwd_data=0, retire_valid=0, retire_pc=0.
- Capture, at each rising edge:
  - stall=1: wb_q holds its value; flush is ignored.
  - stall=0, flush=1: wb_q.valid<=0.
  - otherwise: wb_q<=wb_in_packet, with wb_q.valid<=wb_in_packet.valid_opcode.
- Commit: commit = wb_q.valid & ~stall. retire_valid=commit and retire_pc=wb_q.wb_pc (combinational). A packet is committed exactly once, on the edge on which commit=1.
- Register write: on a commit edge, when wb_q.wb_enable=1 and wb_q.wb_addr!=0, write wb_q.wb_data into regs[wb_addr]. Writes to x0 are discarded.
- Latency: packet presented in cycle N → held in wb_q during N+1 → in the register file from N+2 (absent stall).
- Reads are combinational with write-first bypass:
  - addr=0 → 0.
  - Else, if wb_q.valid & wb_q.wb_enable & (wb_q.wb_addr==addr) → wb_q.wb_data. The bypass also applies while stalled, so the pending value is always visible.
  - Else → regs[addr].
- Forwarding: fwd_valid = wb_q.valid & wb_q.wb_enable & ~wb_q.dont_forward & (wb_q.wb_addr!=0); fwd_addr=wb_q.wb_addr; fwd_data=wb_q.wb_data. The dont_forward bit affects only fwd_valid; register write and read bypass proceed normally.
- Counters, all updated on commit edges:
  - instret += 1 for every committed packet, whether or not wb_enable is set.
  - load_count += 1 if wb_q.is_load; store_count += 1 if wb_q.is_store.
  - All counters wrap modulo 2^width without saturation or flag.
- Boundaries:
  - Back-to-back writes to the same register: the later value wins; the read bypass returns the newest wb_q data.
  - Ports rs1 and rs2 at the same address return identical data.
  - stall deassert and flush in the same cycle: the held wb_q commits; the incoming packet is squashed.

Test Plan:
- Reset mid-run: reset asserted after 3 commits (x3=0x55) → within the same cycle rs1_addr=3 reads 0, instret=0, retire_valid=0; after release, regs still read 0.
- Write/read timing: packet {valid, wb_enable, addr=5, data=0xDEADBEEF} at cycle N → rs1_data=0xDEADBEEF at N+1 via bypass (fwd_valid=1, fwd_addr=5) and at N+2 from regs; instret=1.
- x0 guard: packet {addr=0, data=0x1234, wb_enable} → rs2_addr=0 reads 0, fwd_valid=0, instret increments by 1.
- Stall: valid packet {addr=7, data=0xA5A5A5A5} followed by stall for 3 cycles → retire_valid=0 and rs1(7)=0xA5A5A5A5 throughout; exactly one retire and instret+1 after release.
- Flush: flush=1 with incoming {valid, addr=9, data=0x1} → no retire, rs1(9) unchanged, instret unchanged; stall=1 with flush=1 → wb_q held.
- Mixed retirement: 3 loads, 2 stores (wb_enable=0), 1 ALU op with dont_forward=1 writing x10=0x77 → load_count=3, store_count=2, instret=6; fwd_valid=0 for the ALU op while rs1(10)=0x77.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, 32-entry register file with
// write-first read bypass, EX forwarding source and retirement counters.
package rv32_pkg;
    typedef struct packed {
        logic        valid_opcode;
        logic [31:0] wb_pc;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        wb_enable;
        logic        is_load;
        logic        is_store;
        logic        dont_forward;
    } rv32_mem2wb_packet_t;
endpackage

module wb_stage
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  rv32_mem2wb_packet_t wb_in_packet,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic                fwd_valid,
    output logic [4:0]          fwd_addr,
    output logic [XLEN-1:0]     fwd_data,
    output logic                retire_valid,
    output logic [XLEN-1:0]     retire_pc,
    output logic [CNT_W-1:0]    instret,
    output logic [31:0]         load_count,
    output logic [31:0]         store_count
);

    // The valid_opcode field of the held packet doubles as wb_q.valid.
    rv32_mem2wb_packet_t wb_q_reg;
    logic [XLEN-1:0]     regs_reg [NREGS];
    logic [CNT_W-1:0]    instret_reg;
    logic [31:0]         load_count_reg;
    logic [31:0]         store_count_reg;

    logic wb_valid;
    logic commit;
    logic reg_write;

    assign wb_valid  = wb_q_reg.valid_opcode;
    assign commit    = wb_valid & ~stall;
    assign reg_write = commit & wb_q_reg.wb_enable & (wb_q_reg.wb_addr != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q_reg <= '0;
        end else if (!stall) begin
            if (flush) begin
                wb_q_reg.valid_opcode <= 1'b0;
            end else begin
                wb_q_reg <= wb_in_packet;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (reg_write) begin
            regs_reg[wb_q_reg.wb_addr] <= wb_q_reg.wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_reg     <= '0;
            load_count_reg  <= '0;
            store_count_reg <= '0;
        end else if (commit) begin
            instret_reg <= instret_reg + CNT_W'(1);
            if (wb_q_reg.is_load) begin
                load_count_reg <= load_count_reg + 32'd1;
            end
            if (wb_q_reg.is_store) begin
                store_count_reg <= store_count_reg + 32'd1;
            end
        end
    end

    // Bypass stays active during stall so decode always sees the pending value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
            logic [4:0]      addr;
            logic [XLEN-1:0] data;

            assign addr = (gi == 0) ? rs1_addr : rs2_addr;

            always_comb begin
                data = regs_reg[addr];
                if (addr == 5'd0) begin
                    data = '0;
                end else if (wb_valid && wb_q_reg.wb_enable && (wb_q_reg.wb_addr == addr)) begin
                    data = wb_q_reg.wb_data;
                end
            end
        end
    endgenerate

    assign rs1_data = gen_rd[0].data;
    assign rs2_data = gen_rd[1].data;

    assign fwd_valid = wb_valid & wb_q_reg.wb_enable & ~wb_q_reg.dont_forward
                     & (wb_q_reg.wb_addr != 5'd0);
    assign fwd_addr  = wb_q_reg.wb_addr;
    assign fwd_data  = wb_q_reg.wb_data;

    assign retire_valid = commit;
    assign retire_pc    = wb_q_reg.wb_pc;

    assign instret     = instret_reg;
    assign load_count  = load_count_reg;
    assign store_count = store_count_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the write-back stage.
module tb_wb_stage;
    import rv32_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                stall;
    logic                flush;
    rv32_mem2wb_packet_t pkt;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [31:0]         rs1_data;
    logic [31:0]         rs2_data;
    logic                fwd_valid;
    logic [4:0]          fwd_addr;
    logic [31:0]         fwd_data;
    logic                retire_valid;
    logic [31:0]         retire_pc;
    logic [63:0]         instret;
    logic [31:0]         load_count;
    logic [31:0]         store_count;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .wb_in_packet (pkt),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .fwd_valid    (fwd_valid),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .instret      (instret),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural state plus the one instruction in flight.
    logic [31:0]         m_regs [32];
    rv32_mem2wb_packet_t m_pend;
    logic                m_pend_v;
    logic [63:0]         m_instret;
    logic [31:0]         m_loads;
    logic [31:0]         m_stores;

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend    = '0;
        m_pend_v  = 1'b0;
        m_instret = 64'd0;
        m_loads   = 32'd0;
        m_stores  = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_pend_v && m_pend.wb_enable && m_pend.wb_addr == a) return m_pend.wb_data;
        return m_regs[a];
    endfunction

    function automatic logic m_fwd();
        return m_pend_v && m_pend.wb_enable && !m_pend.dont_forward && m_pend.wb_addr != 5'd0;
    endfunction

    function automatic rv32_mem2wb_packet_t mk(input logic v, input logic en, input logic [4:0] a,
                                               input logic [31:0] d, input logic ld, input logic st,
                                               input logic df);
        rv32_mem2wb_packet_t p;
        p.valid_opcode = v;
        p.wb_pc        = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        p.wb_addr      = a;
        p.wb_data      = d;
        p.wb_enable    = en;
        p.is_load      = ld;
        p.is_store     = st;
        p.dont_forward = df;
        return p;
    endfunction

    // One rising edge: model retires/captures exactly what the DUT sees, then settle.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            if (m_pend_v && !stall) begin
                m_instret = m_instret + 64'd1;
                if (m_pend.is_load)  m_loads  = m_loads + 32'd1;
                if (m_pend.is_store) m_stores = m_stores + 32'd1;
                if (m_pend.wb_enable && m_pend.wb_addr != 5'd0) m_regs[m_pend.wb_addr] = m_pend.wb_data;
            end
            if (!stall) begin
                if (flush) m_pend_v = 1'b0;
                else begin
                    m_pend   = pkt;
                    m_pend_v = pkt.valid_opcode;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        pkt   = '0;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        rs1_addr = 5'd3;
        rs2_addr = 5'd3;
        m_clear();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || fwd_valid !== 1'b0 || fwd_addr !== 5'd0 ||
            fwd_data !== 32'd0 || retire_valid !== 1'b0 || retire_pc !== 32'd0 ||
            instret !== 64'd0 || load_count !== 32'd0 || store_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rs1=%h rs2=%h fv=%b fa=%0d fd=%h rv=%b rpc=%h ir=%0d lc=%0d sc=%0d, expected all zero",
                     rs1_data, rs2_data, fwd_valid, fwd_addr, fwd_data, retire_valid, retire_pc,
                     instret, load_count, store_count);
        end
        // Three commits to x3, then an asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            pkt = mk(1'b1, 1'b1, 5'd3, 32'h55, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        checks++;
        if (instret !== 64'd3 || rs1_data !== 32'h55) begin
            errors++;
            $display("FAIL reset_precommit: instret=%0d rs1=%h, expected 3 and 00000055", instret, rs1_data);
        end
        pkt = mk(1'b1, 1'b1, 5'd3, 32'h66, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        m_clear();
        #1;
        checks++;
        if (rs1_data !== 32'd0 || instret !== 64'd0 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rs1=%h instret=%0d retire_valid=%b, expected 0 0 0",
                     rs1_data, instret, retire_valid);
        end
        idle();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (rs1_data !== 32'd0 || instret !== 64'd0) begin
            errors++;
            $display("FAIL reset_release: rs1=%h instret=%0d, expected 0 0", rs1_data, instret);
        end
    endtask

    task automatic test_write_read();
        pkt = mk(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        rs1_addr = 5'd5;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'hDEADBEEF || fwd_valid !== 1'b1 || fwd_addr !== 5'd5 ||
            fwd_data !== 32'hDEADBEEF || retire_valid !== 1'b1 || retire_pc !== m_pend.wb_pc ||
            instret !== 64'd0) begin
            errors++;
            $display("FAIL write_bypass: rs1=%h fv=%b fa=%0d fd=%h rv=%b pc=%h ir=%0d, expected deadbeef 1 5 deadbeef 1 %h 0",
                     rs1_data, fwd_valid, fwd_addr, fwd_data, retire_valid, retire_pc, instret, m_pend.wb_pc);
        end
        tick();
        checks++;
        if (rs1_data !== 32'hDEADBEEF || instret !== 64'd1 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_regfile: rs1=%h instret=%0d fv=%b, expected deadbeef 1 0",
                     rs1_data, instret, fwd_valid);
        end
    endtask

    task automatic test_x0();
        logic [63:0] base;
        base = m_instret;
        pkt = mk(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b0);
        rs2_addr = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'd0 || fwd_valid !== 1'b0 || retire_valid !== 1'b1) begin
            errors++;
            $display("FAIL x0_guard: rs2=%h fv=%b rv=%b, expected 0 0 1", rs2_data, fwd_valid, retire_valid);
        end
        tick();
        checks++;
        if (rs2_data !== 32'd0 || instret !== base + 64'd1) begin
            errors++;
            $display("FAIL x0_commit: rs2=%h instret=%0d, expected 0 %0d", rs2_data, instret, base + 64'd1);
        end
    endtask

    task automatic test_stall();
        logic [63:0] base;
        base = m_instret;
        pkt = mk(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        rs1_addr = 5'd7;
        tick();
        idle();
        stall = 1'b1;
        pkt = mk(1'b1, 1'b1, 5'd7, 32'h0BAD0BAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (retire_valid !== 1'b0 || rs1_data !== 32'hA5A5A5A5 || instret !== base) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rv=%b rs1=%h ir=%0d, expected 0 a5a5a5a5 %0d",
                         i, retire_valid, rs1_data, instret, base);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (retire_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: rv=%b, expected 1", retire_valid);
        end
        tick();
        checks++;
        if (instret !== base + 64'd1 || retire_valid !== 1'b0 || rs1_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL stall_once: ir=%0d rv=%b rs1=%h, expected %0d 0 a5a5a5a5",
                     instret, retire_valid, rs1_data, base + 64'd1);
        end
    endtask

    task automatic test_flush();
        logic [63:0] base;
        logic [31:0] prior;
        base  = m_instret;
        prior = m_regs[9];
        rs1_addr = 5'd9;
        pkt   = mk(1'b1, 1'b1, 5'd9, 32'h1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (retire_valid !== 1'b0 || rs1_data !== prior || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_squash: rv=%b rs1=%h fv=%b, expected 0 %h 0", retire_valid, rs1_data, fwd_valid, prior);
        end
        tick();
        checks++;
        if (instret !== base || rs1_data !== prior) begin
            errors++;
            $display("FAIL flush_count: ir=%0d rs1=%h, expected %0d %h", instret, rs1_data, base, prior);
        end
        // Stall outranks flush: the held packet survives and later commits.
        rs1_addr = 5'd11;
        pkt = mk(1'b1, 1'b1, 5'd11, 32'hCAFE, 1'b0, 1'b0, 1'b0);
        tick();
        stall = 1'b1;
        flush = 1'b1;
        pkt = mk(1'b1, 1'b1, 5'd11, 32'h9999, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (rs1_data !== 32'hCAFE || fwd_valid !== 1'b1 || retire_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_under_stall: rs1=%h fv=%b rv=%b, expected 0000cafe 1 0", rs1_data, fwd_valid, retire_valid);
        end
        // Stall release with flush: held packet commits, incoming is squashed.
        stall = 1'b0;
        tick();
        idle();
        tick();
        checks++;
        if (rs1_data !== 32'hCAFE || instret !== base + 64'd1) begin
            errors++;
            $display("FAIL flush_release: rs1=%h ir=%0d, expected 0000cafe %0d", rs1_data, instret, base + 64'd1);
        end
    endtask

    task automatic test_mixed();
        logic [63:0] ibase;
        logic [31:0] lbase;
        logic [31:0] sbase;
        ibase = m_instret;
        lbase = m_loads;
        sbase = m_stores;
        rs1_addr = 5'd10;
        for (int i = 0; i < 3; i++) begin
            pkt = mk(1'b1, 1'b1, 5'(12 + i), $urandom, 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            pkt = mk(1'b1, 1'b0, 5'(20 + i), $urandom, 1'b0, 1'b1, 1'b0);
            tick();
        end
        pkt = mk(1'b1, 1'b1, 5'd10, 32'h77, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        checks++;
        if (fwd_valid !== 1'b0 || rs1_data !== 32'h77) begin
            errors++;
            $display("FAIL mixed_dont_forward: fv=%b rs1=%h, expected 0 00000077", fwd_valid, rs1_data);
        end
        tick();
        checks++;
        if (load_count !== lbase + 32'd3 || store_count !== sbase + 32'd2 ||
            instret !== ibase + 64'd6 || rs1_data !== 32'h77) begin
            errors++;
            $display("FAIL mixed_counts: lc=%0d sc=%0d ir=%0d rs1=%h, expected %0d %0d %0d 00000077",
                     load_count, store_count, instret, rs1_data, lbase + 32'd3, sbase + 32'd2, ibase + 64'd6);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v1;
        logic [31:0] v2;
        v1 = $urandom;
        v2 = ~v1;
        rs1_addr = 5'd20;
        rs2_addr = 5'd20;
        pkt = mk(1'b1, 1'b1, 5'd20, v1, 1'b0, 1'b0, 1'b0);
        tick();
        pkt = mk(1'b1, 1'b1, 5'd20, v2, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== v2 || rs2_data !== v2) begin
            errors++;
            $display("FAIL b2b_bypass: rs1=%h rs2=%h, expected %h", rs1_data, rs2_data, v2);
        end
        tick();
        checks++;
        if (rs1_data !== v2 || rs2_data !== v2) begin
            errors++;
            $display("FAIL b2b_regfile: rs1=%h rs2=%h, expected %h", rs1_data, rs2_data, v2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            pkt = mk($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                     $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (rs1_data !== m_read(rs1_addr) || rs2_data !== m_read(rs2_addr)) begin
                errors++;
                $display("FAIL rand_read[%0d]: rs1(%0d)=%h rs2(%0d)=%h, expected %h %h", n, rs1_addr,
                         rs1_data, rs2_addr, rs2_data, m_read(rs1_addr), m_read(rs2_addr));
            end
            checks++;
            if (fwd_valid !== m_fwd() || (m_fwd() && (fwd_addr !== m_pend.wb_addr || fwd_data !== m_pend.wb_data))) begin
                errors++;
                $display("FAIL rand_fwd[%0d]: fv=%b fa=%0d fd=%h, expected %b %0d %h", n, fwd_valid,
                         fwd_addr, fwd_data, m_fwd(), m_pend.wb_addr, m_pend.wb_data);
            end
            checks++;
            if (retire_valid !== (m_pend_v & ~stall) || (m_pend_v && retire_pc !== m_pend.wb_pc)) begin
                errors++;
                $display("FAIL rand_retire[%0d]: rv=%b pc=%h, expected %b %h", n, retire_valid,
                         retire_pc, m_pend_v & ~stall, m_pend.wb_pc);
            end
            checks++;
            if (instret !== m_instret || load_count !== m_loads || store_count !== m_stores) begin
                errors++;
                $display("FAIL rand_counters[%0d]: ir=%0d lc=%0d sc=%0d, expected %0d %0d %0d", n,
                         instret, load_count, store_count, m_instret, m_loads, m_stores);
            end
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        idle();
        reset    = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        m_clear();
        test_reset();
        test_write_read();
        test_x0();
        test_stall();
        test_flush();
        test_mixed();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
